// File: rtl/mor1kx_dpram_fifo_ctrl.sv
// FIFO controller for an external dual-port RAM (A = write, B = registered read),
// with a two-entry skid buffer that gives first-word-fall-through output at full rate.
module mor1kx_dpram_fifo_ctrl #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   output logic                    rd_valid,
   input  logic                    rd_ready,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic [ADDR_WIDTH+1:0]   count,
   output logic [ADDR_WIDTH-1:0]   ram_addr_a,
   output logic                    ram_we_a,
   output logic [DATA_WIDTH-1:0]   ram_din_a,
   output logic [ADDR_WIDTH-1:0]   ram_addr_b,
   output logic                    ram_we_b,
   output logic [DATA_WIDTH-1:0]   ram_din_b,
   input  logic [DATA_WIDTH-1:0]   ram_dout_b
);

   localparam int unsigned PTR_W = ADDR_WIDTH + 1;
   localparam int unsigned CNT_W = ADDR_WIDTH + 2;
   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   logic [PTR_W-1:0]      wptr;
   logic [PTR_W-1:0]      rptr;
   logic [PTR_W-1:0]      ram_count;
   logic                  pending;
   logic [1:0]            skid_cnt;
   logic [1:0]            skid_cnt_next;
   logic [1:0]            cap_slot;
   logic [DATA_WIDTH-1:0] skid_head;
   logic [DATA_WIDTH-1:0] skid_tail;
   logic                  ram_full;
   logic                  ram_empty;
   logic                  push;
   logic                  pop;
   logic                  issue;

   // Occupancy and handshake decode from registered state
   always_comb begin
      ram_count     = wptr - rptr;
      ram_full      = (ram_count == PTR_W'(DEPTH));
      ram_empty     = (ram_count == '0);
      wr_ready      = ~ram_full;
      push          = wr_valid & ~ram_full & ~flush;
      rd_valid      = (skid_cnt != 2'd0);
      pop           = rd_valid & rd_ready;
      // skid + in-flight - pop never exceeds 2, so two bits suffice
      skid_cnt_next = skid_cnt + {1'b0, pending} - {1'b0, pop};
      issue         = ~ram_empty & (skid_cnt_next < 2'd2) & ~flush;
      cap_slot      = skid_cnt - {1'b0, pop};
      count         = CNT_W'(ram_count) + CNT_W'(skid_cnt) + CNT_W'(pending);
   end

   // RAM port drive
   always_comb begin
      ram_we_a   = push;
      ram_addr_a = wptr[ADDR_WIDTH-1:0];
      ram_din_a  = wr_data;
      ram_addr_b = rptr[ADDR_WIDTH-1:0];
      ram_we_b   = 1'b0;
      ram_din_b  = '0;
      rd_data    = skid_head;
   end

   // Pointers, read-in-flight flag and skid buffer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr      <= '0;
         rptr      <= '0;
         pending   <= 1'b0;
         skid_cnt  <= 2'd0;
         skid_head <= '0;
         skid_tail <= '0;
      end else if (flush) begin
         wptr     <= '0;
         rptr     <= '0;
         pending  <= 1'b0;
         skid_cnt <= 2'd0;
      end else begin
         if (push)
            wptr <= wptr + PTR_W'(1);
         if (issue)
            rptr <= rptr + PTR_W'(1);
         pending  <= issue;
         skid_cnt <= skid_cnt_next;
         if (pop)
            skid_head <= skid_tail;
         // Capture lands after the pop shift, so it overrides the shifted slot
         if (pending) begin
            if (cap_slot == 2'd0)
               skid_head <= ram_dout_b;
            else
               skid_tail <= ram_dout_b;
         end
      end
   end

endmodule

// File: tb/tb_mor1kx_dpram_fifo_ctrl.sv
// Directed bench for mor1kx_dpram_fifo_ctrl with a behavioural registered-read RAM.
module tb_mor1kx_dpram_fifo_ctrl;

   localparam int AW    = 4;
   localparam int DW    = 32;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [DW-1:0] wr_data = '0;
   logic          rd_valid;
   logic          rd_ready = 1'b0;
   logic [DW-1:0] rd_data;
   logic [AW+1:0] count;
   logic [AW-1:0] ram_addr_a;
   logic          ram_we_a;
   logic [DW-1:0] ram_din_a;
   logic [AW-1:0] ram_addr_b;
   logic          ram_we_b;
   logic [DW-1:0] ram_din_b;
   logic [DW-1:0] ram_dout_b = '0;

   logic [DW-1:0] mem [DEPTH];

   int checks   = 0;
   int failures = 0;

   mor1kx_dpram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .count(count),
      .ram_addr_a(ram_addr_a), .ram_we_a(ram_we_a), .ram_din_a(ram_din_a),
      .ram_addr_b(ram_addr_b), .ram_we_b(ram_we_b), .ram_din_b(ram_din_b),
      .ram_dout_b(ram_dout_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we_a)
         mem[ram_addr_a] <= ram_din_a;
      ram_dout_b <= mem[ram_addr_b];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1;
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid: got %0b expected 0", rd_valid); end
      checks++; if (rd_data !== 32'h0) begin failures++; $display("FAIL reset_rd_data: got %0h expected 0", rd_data); end
      checks++; if (count !== 6'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", count); end
      checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready: got %0b expected 1", wr_ready); end
      checks++;
      if ({ram_we_a, ram_addr_a, ram_addr_b, ram_we_b, ram_din_b} !== 42'h0) begin
         failures++;
         $display("FAIL reset_ram_ports: got we_a=%0b addr_a=%0h addr_b=%0h we_b=%0b din_b=%0h expected all 0",
                  ram_we_a, ram_addr_a, ram_addr_b, ram_we_b, ram_din_b);
      end
      @(negedge clk);
      rst = 1'b0;
      step();
   endtask

   task automatic test_single_word();
      wr_valid = 1'b1; wr_data = 32'hA5A5_0001; rd_ready = 1'b0;
      #1;
      checks++; if (ram_we_a !== 1'b1) begin failures++; $display("FAIL single_we_a: got %0b expected 1", ram_we_a); end
      checks++; if (ram_addr_a !== 4'd0) begin failures++; $display("FAIL single_addr_a: got %0d expected 0", ram_addr_a); end
      checks++; if (ram_din_a !== 32'hA5A5_0001) begin failures++; $display("FAIL single_din_a: got %0h expected a5a50001", ram_din_a); end
      step();   // E0
      wr_valid = 1'b0;
      #1;
      checks++; if (ram_addr_b !== 4'd0) begin failures++; $display("FAIL single_addr_b_c1: got %0d expected 0", ram_addr_b); end
      checks++; if (count !== 6'd1) begin failures++; $display("FAIL single_count_c1: got %0d expected 1", count); end
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL single_rd_valid_c1: got %0b expected 0", rd_valid); end
      step();   // E1: read issued
      checks++; if (ram_addr_b !== 4'd1) begin failures++; $display("FAIL single_addr_b_c2: got %0d expected 1", ram_addr_b); end
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL single_rd_valid_c2: got %0b expected 0", rd_valid); end
      step();   // E2: captured
      checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL single_rd_valid_c3: got %0b expected 1", rd_valid); end
      checks++; if (rd_data !== 32'hA5A5_0001) begin failures++; $display("FAIL single_rd_data: got %0h expected a5a50001", rd_data); end
      checks++; if (count !== 6'd1) begin failures++; $display("FAIL single_count_c3: got %0d expected 1", count); end
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
      checks++; if (rd_valid !== 1'b0 || count !== 6'd0) begin failures++; $display("FAIL single_after_pop: got valid=%0b count=%0d expected 0/0", rd_valid, count); end
   endtask

   task automatic test_fill();
      int accepted = 0;
      int got = 0;
      rd_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         wr_valid = 1'b1; wr_data = DW'(i);
         #1;
         if (wr_ready) accepted++;
         step();
      end
      wr_valid = 1'b0;
      checks++; if (accepted != 18) begin failures++; $display("FAIL fill_accepted: got %0d expected 18", accepted); end
      checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL fill_wr_ready: got %0b expected 0", wr_ready); end
      checks++; if (count !== 6'd18) begin failures++; $display("FAIL fill_count: got %0d expected 18", count); end
      wr_valid = 1'b1; wr_data = 32'hDEAD_BEEF;
      step();
      wr_valid = 1'b0;
      checks++; if (count !== 6'd18) begin failures++; $display("FAIL fill_push_when_full: got count %0d expected 18", count); end
      rd_ready = 1'b1;
      for (int cyc = 0; cyc < 100 && got < 18; cyc++) begin
         if (rd_valid) begin
            checks++;
            if (rd_data !== DW'(got)) begin failures++; $display("FAIL fill_drain_data: got %0h expected %0h", rd_data, got); end
            got++;
         end
         step();
      end
      rd_ready = 1'b0;
      checks++; if (got != 18) begin failures++; $display("FAIL fill_drain_count: got %0d words expected 18", got); end
      checks++; if (count !== 6'd0) begin failures++; $display("FAIL fill_drain_empty: got count %0d expected 0", count); end
   endtask

   task automatic test_streaming();
      int sent = 0;
      int got = 0;
      int first = -1;
      int gaps = 0;
      rd_ready = 1'b1;
      for (int cyc = 0; cyc < 200 && got < 100; cyc++) begin
         wr_valid = (sent < 100);
         wr_data  = 32'h1000_0000 + DW'(sent);
         #1;
         if (wr_valid && wr_ready) sent++;
         if (rd_valid) begin
            checks++;
            if (rd_data !== 32'h1000_0000 + DW'(got)) begin failures++; $display("FAIL stream_data: got %0h expected %0h", rd_data, 32'h1000_0000 + DW'(got)); end
            got++;
            if (first < 0) first = cyc;
         end else if (first >= 0) begin
            gaps++;
         end
         step();
      end
      wr_valid = 1'b0; rd_ready = 1'b0;
      checks++; if (first != 3) begin failures++; $display("FAIL stream_latency: got first valid cycle %0d expected 3", first); end
      checks++; if (gaps != 0) begin failures++; $display("FAIL stream_gaps: got %0d expected 0", gaps); end
      checks++; if (got != 100) begin failures++; $display("FAIL stream_words: got %0d expected 100", got); end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] q [$];
      logic          do_push;
      logic          do_pop;
      logic [DW-1:0] v;
      for (int cyc = 0; cyc < 400; cyc++) begin
         rd_ready = (cyc % 2 == 0) && (cyc < 300);
         wr_valid = (cyc < 300) && ($urandom_range(0, 3) != 0);
         v        = 32'h2000_0000 + DW'(cyc);
         wr_data  = v;
         #1;
         if (cyc >= 300) rd_ready = 1'b1;
         #1;
         do_push = wr_valid & wr_ready;
         do_pop  = rd_valid & rd_ready;
         if (do_pop) begin
            checks++;
            if (q.size() == 0) begin
               failures++; $display("FAIL bp_underflow: got pop of %0h expected no data", rd_data);
            end else begin
               if (rd_data !== q[0]) begin failures++; $display("FAIL bp_data: got %0h expected %0h", rd_data, q[0]); end
               void'(q.pop_front());
            end
         end
         if (do_push) q.push_back(v);
         step();
         checks++;
         if (count !== 6'(q.size()) || count > 6'd18) begin failures++; $display("FAIL bp_count: got %0d expected %0d", count, q.size()); end
         if (cyc >= 300 && q.size() == 0) break;
      end
      wr_valid = 1'b0; rd_ready = 1'b0;
      checks++; if (q.size() != 0) begin failures++; $display("FAIL bp_drain: got %0d left expected 0", q.size()); end
   endtask

   task automatic test_flush();
      int waited = 0;
      rd_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         wr_valid = 1'b1; wr_data = 32'hF0 + DW'(i);
         step();
      end
      // skid holds one word and a second read is in flight here
      checks++; if (count !== 6'd3 || rd_valid !== 1'b1) begin failures++; $display("FAIL flush_pre: got count=%0d valid=%0b expected 3/1", count, rd_valid); end
      flush = 1'b1; wr_valid = 1'b1; wr_data = 32'hBAD; rd_ready = 1'b1;
      step();
      flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
      #1;
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL flush_rd_valid: got %0b expected 0", rd_valid); end
      checks++; if (count !== 6'd0) begin failures++; $display("FAIL flush_count: got %0d expected 0", count); end
      checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL flush_wr_ready: got %0b expected 1", wr_ready); end
      step();
      checks++; if (rd_valid !== 1'b0 || count !== 6'd0) begin failures++; $display("FAIL flush_stale_capture: got valid=%0b count=%0d expected 0/0", rd_valid, count); end
      wr_valid = 1'b1; wr_data = 32'h55;
      step();
      wr_valid = 1'b0;
      while (!rd_valid && waited < 10) begin step(); waited++; end
      checks++; if (!rd_valid || rd_data !== 32'h55) begin failures++; $display("FAIL flush_first_word: got valid=%0b data=%0h expected 1/55", rd_valid, rd_data); end
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
      checks++; if (count !== 6'd0) begin failures++; $display("FAIL flush_final_count: got %0d expected 0", count); end
   endtask

   task automatic test_async_reset();
      int got = 0;
      rd_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wr_valid = 1'b1; wr_data = 32'h300 + DW'(i);
         step();
      end
      wr_valid = 1'b0; rd_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checks++; if (rd_valid !== 1'b0 || rd_data !== 32'h0) begin failures++; $display("FAIL areset_rd: got valid=%0b data=%0h expected 0/0", rd_valid, rd_data); end
      checks++; if (count !== 6'd0 || wr_ready !== 1'b1) begin failures++; $display("FAIL areset_count: got count=%0d wr_ready=%0b expected 0/1", count, wr_ready); end
      checks++; if ({ram_we_a, ram_addr_a, ram_addr_b} !== 9'h0) begin failures++; $display("FAIL areset_ram: got we_a=%0b addr_a=%0h addr_b=%0h expected 0", ram_we_a, ram_addr_a, ram_addr_b); end
      step();
      @(negedge clk);
      rst = 1'b0;
      step();
      checks++; if (rd_valid !== 1'b0 || count !== 6'd0) begin failures++; $display("FAIL areset_release: got valid=%0b count=%0d expected 0/0", rd_valid, count); end
      rd_ready = 1'b1;
      for (int cyc = 0; cyc < 20 && got < 2; cyc++) begin
         wr_valid = (cyc < 2);
         wr_data  = 32'h77 + DW'(cyc);
         #1;
         if (rd_valid) begin
            checks++;
            if (rd_data !== 32'h77 + DW'(got)) begin failures++; $display("FAIL areset_data: got %0h expected %0h", rd_data, 32'h77 + DW'(got)); end
            got++;
         end
         step();
      end
      wr_valid = 1'b0; rd_ready = 1'b0;
      checks++; if (got != 2) begin failures++; $display("FAIL areset_words: got %0d expected 2", got); end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_fill();
      test_streaming();
      test_backpressure();
      test_flush();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
